// File: rtl/int16_serial_subtractor.sv
// Multi-cycle subtractor y = a - b, resolving BITS_PER_CYCLE bits per clock through
// full-adder cells fed with ~b and carry-in 1; valid/ready handshakes on both sides.
module int16_serial_subtractor #(
  parameter int WORD_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] y,
  output logic                  borrow,
  output logic                  ovf
);

  localparam int NUM_STEPS = WORD_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  generate
    if ((WORD_WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WORD_WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_params
      $error("int16_serial_subtractor: WORD_WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Full-adder cell shared with the adder wrapper: returns {cout, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic z, input logic c);
    return {(x & z) | (x & c) | (z & c), x ^ z ^ c};
  endfunction

  state_t                    state_r, state_next_s;
  logic                      in_ready_r, out_valid_r;
  logic [WORD_WIDTH-1:0]     a_sh_r, b_sh_r, res_sh_r, res_next_s;
  logic [BITS_PER_CYCLE-1:0] sum_s;
  logic                      carry_r, cout_s;
  logic [CNT_W-1:0]          count_r;
  logic                      a_msb_r, b_msb_r;
  logic                      accept_s, last_step_s;
  logic [WORD_WIDTH-1:0]     y_r;
  logic                      borrow_r, ovf_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign borrow    = borrow_r;
  assign ovf       = ovf_r;

  assign accept_s    = (state_r == IDLE) && in_valid;
  assign last_step_s = (count_r == LAST_STEP);
  // New sum bits enter at the MSB end; the dropped low bits are already consumed.
  assign res_next_s  = WORD_WIDTH'({sum_s, res_sh_r} >> BITS_PER_CYCLE);

  // Ripple the current slice of A, ~B and the running carry through the cells.
  always_comb begin : p_add
    logic       c_v;
    logic [1:0] fa_v;
    c_v   = carry_r;
    fa_v  = 2'b00;
    sum_s = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      fa_v     = full_add(a_sh_r[i], b_sh_r[i], c_v);
      sum_s[i] = fa_v[0];
      c_v      = fa_v[1];
    end
    cout_s = c_v;
  end

  // Next-state decode for the handshake FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (last_step_s) state_next_s = DONE;
        else             state_next_s = RUN;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand capture and per-cycle shift/carry/count update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      carry_r  <= 1'b0;
      count_r  <= '0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
    end else if (accept_s) begin
      a_sh_r   <= a;
      b_sh_r   <= ~b;
      res_sh_r <= '0;
      carry_r  <= 1'b1;
      count_r  <= '0;
      a_msb_r  <= a[WORD_WIDTH-1];
      b_msb_r  <= b[WORD_WIDTH-1];
    end else if (state_r == RUN) begin
      a_sh_r   <= a_sh_r >> BITS_PER_CYCLE;
      b_sh_r   <= b_sh_r >> BITS_PER_CYCLE;
      res_sh_r <= res_next_s;
      carry_r  <= cout_s;
      count_r  <= count_r + CNT_W'(1);
    end else begin
      count_r  <= count_r;
    end
  end

  // Result commit on the final RUN edge; held until the next commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_r      <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if ((state_r == RUN) && last_step_s) begin
      y_r      <= res_next_s;
      borrow_r <= ~cout_s;
      ovf_r    <= (a_msb_r != b_msb_r) && (res_next_s[WORD_WIDTH-1] != a_msb_r);
    end else begin
      y_r      <= y_r;
    end
  end

endmodule

// File: tb/tb_int16_serial_subtractor.sv
// Directed bench for int16_serial_subtractor: one-bit-per-cycle instance plus a
// four-bits-per-cycle instance with a randomised sweep against a golden a - b.
module tb_int16_serial_subtractor;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, borrow0, ovf0;
  logic [15:0] a0, b0, y0;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, borrow4, ovf4;
  logic [15:0] a4, b4, y4;

  int checks = 0;
  int errors = 0;
  int cyc;

  int16_serial_subtractor #(.WORD_WIDTH(16), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .y(y0), .borrow(borrow0), .ovf(ovf0)
  );

  int16_serial_subtractor #(.WORD_WIDTH(16), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .y(y4), .borrow(borrow4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair to the 1-bit instance, scramble inputs after
  // acceptance and count edges until out_valid (bounded).
  task automatic run0(input logic [15:0] ta, input logic [15:0] tb, output int n);
    @(negedge clk);
    a0 = ta; b0 = tb; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0; a0 = ~ta; b0 = ~tb;
    n = 0;
    while (!out_valid0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run4(input logic [15:0] ta, input logic [15:0] tb, output int n);
    @(negedge clk);
    a4 = ta; b4 = tb; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = ~ta; b4 = ~tb;
    n = 0;
    while (!out_valid4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One accepted edge in DONE with out_ready high: back to IDLE.
  task automatic release0(input string tag);
    @(posedge clk); #1;
    check({tag, " out_valid drop"}, {31'd0, out_valid0}, 32'd0);
    check({tag, " in_ready back"}, {31'd0, in_ready0}, 32'd1);
  endtask

  task automatic op0(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                     input logic [15:0] ey, input logic eb, input logic eo);
    int n;
    run0(ta, tb, n);
    check({tag, " latency"}, n, 32'd16);
    check({tag, " y/borrow/ovf"}, {14'd0, y0, borrow0, ovf0}, {14'd0, ey, eb, eo});
    release0(tag);
  endtask

  initial begin
    logic [15:0] ra, rb, gy;
    logic        gb, go;
    in_valid0 = 1'b0; out_ready0 = 1'b1; a0 = 16'h0000; b0 = 16'h0000;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = 16'h0000; b4 = 16'h0000;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'd0, in_ready0}, 32'd1);
    check("reset out_valid", {31'd0, out_valid0}, 32'd0);
    check("reset y/borrow/ovf", {14'd0, y0, borrow0, ovf0}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    op0("5-3", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    op0("3-5", 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
    op0("0-0", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    op0("8000-0001", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    op0("7FFF-FFFF", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

    // Abort mid-RUN: outputs collapse to reset values immediately.
    @(negedge clk);
    a0 = 16'h1234; b0 = 16'h0034; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid0}, 32'd0);
    check("abort in_ready", {31'd0, in_ready0}, 32'd1);
    check("abort y/borrow/ovf", {14'd0, y0, borrow0, ovf0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post-abort in_ready", {31'd0, in_ready0}, 32'd1);
    op0("1234-0034", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0);

    // Backpressure: result held, no accept while DONE.
    out_ready0 = 1'b0;
    run0(16'h0010, 16'h0020, cyc);
    check("bp latency", cyc, 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom);
      @(posedge clk); #1;
      check("bp out_valid held", {31'd0, out_valid0}, 32'd1);
      check("bp in_ready low", {31'd0, in_ready0}, 32'd0);
      check("bp y/borrow/ovf", {14'd0, y0, borrow0, ovf0}, {14'd0, 16'hFFF0, 1'b1, 1'b0});
    end
    @(negedge clk);
    in_valid0 = 1'b0; out_ready0 = 1'b1;
    release0("bp");
    check("bp y kept in IDLE", {16'd0, y0}, 32'h0000FFF0);

    // Four bits per cycle.
    run4(16'hABCD, 16'h1111, cyc);
    check("bpc4 latency", cyc, 32'd4);
    check("bpc4 y/borrow/ovf", {14'd0, y4, borrow4, ovf4}, {14'd0, 16'h9ABC, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("bpc4 in_ready back", {31'd0, in_ready4}, 32'd1);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) begin
        ra = 16'h0000; rb = 16'hFFFF;
      end else begin
        ra = ra;
      end
      gy = ra - rb;
      gb = (ra < rb);
      go = (ra[15] != rb[15]) && (gy[15] != ra[15]);
      run4(ra, rb, cyc);
      if (cyc != 4) begin
        check("sweep latency", cyc, 32'd4);
      end else begin
        cyc = cyc;
      end
      check("sweep y/borrow/ovf", {14'd0, y4, borrow4, ovf4}, {14'd0, gy, gb, go});
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
